// File: rtl/parity_stream_checker.sv
// Streaming parity checker: per-word error, per-frame error/length, sticky status.
// Define PARITY_ERR_CNT_EN to build the saturating err_count register; otherwise err_count is tied to 0.
module parity_stream_checker #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             odd_mode,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_par,
  input  logic             in_last,
  input  logic             clr_err,
  output logic             out_valid,
  output logic             word_err,
  output logic             frame_done,
  output logic             frame_err,
  output logic [CNT_W-1:0] frame_len,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [0:0]       state_q, state_d;
  logic             frame_mode_q, frame_mode_d;
  logic             acc_err_q, acc_err_d;
  logic [CNT_W-1:0] acc_len_q, acc_len_d;
  logic             out_valid_q, out_valid_d;
  logic             word_err_q, word_err_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_err_q, frame_err_d;
  logic [CNT_W-1:0] frame_len_q, frame_len_d;
  logic             err_sticky_q, err_sticky_d;

  logic             first_word;
  logic             mode_eff;
  logic             err_now;
  logic             acc_err_new;
  logic [CNT_W-1:0] acc_len_new;

  // The first beat of a frame is judged by the live mode; later beats use the captured one.
  always_comb begin
    first_word  = (state_q == ST_IDLE);
    mode_eff    = first_word ? odd_mode : frame_mode_q;
    err_now     = in_valid & ((^{in_data, in_par}) ^ mode_eff);
    acc_err_new = first_word ? err_now : (acc_err_q | err_now);
    if (first_word) begin
      acc_len_new = CNT_W'(1);
    end else if (acc_len_q == CNT_MAX) begin
      acc_len_new = CNT_MAX;
    end else begin
      acc_len_new = acc_len_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    frame_mode_d = frame_mode_q;
    acc_err_d    = acc_err_q;
    acc_len_d    = acc_len_q;
    out_valid_d  = in_valid;
    word_err_d   = err_now;
    frame_done_d = 1'b0;
    frame_err_d  = frame_err_q;
    frame_len_d  = frame_len_q;
    err_sticky_d = err_now | (err_sticky_q & ~clr_err);
    if (in_valid) begin
      acc_err_d = acc_err_new;
      acc_len_d = acc_len_new;
      if (first_word) begin
        frame_mode_d = odd_mode;
      end
      if (in_last) begin
        state_d      = ST_IDLE;
        frame_done_d = 1'b1;
        frame_err_d  = acc_err_new;
        frame_len_d  = acc_len_new;
      end else begin
        state_d = ST_ACTIVE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      frame_mode_q <= 1'b0;
      acc_err_q    <= 1'b0;
      acc_len_q    <= '0;
      out_valid_q  <= 1'b0;
      word_err_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      frame_len_q  <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_mode_q <= frame_mode_d;
      acc_err_q    <= acc_err_d;
      acc_len_q    <= acc_len_d;
      out_valid_q  <= out_valid_d;
      word_err_q   <= word_err_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      frame_len_q  <= frame_len_d;
      err_sticky_q <= err_sticky_d;
    end
  end

`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] err_count_q, err_count_d;

  // A clear coinciding with an error leaves that error counted.
  always_comb begin
    err_count_d = err_count_q;
    if (clr_err) begin
      err_count_d = err_now ? CNT_W'(1) : '0;
    end else if (err_now && (err_count_q != CNT_MAX)) begin
      err_count_d = err_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = '0;
`endif

  assign out_valid  = out_valid_q;
  assign word_err   = word_err_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign frame_len  = frame_len_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_parity_stream_checker.sv
// Scoreboard bench for parity_stream_checker: directed cases plus randomized traffic
// checked against a frame-level reference model.
module tb_parity_stream_checker;
  localparam int WIDTH = 8;
  localparam int CNT_W = 3;
  localparam int MAXV  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             odd_mode;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_par;
  logic             in_last;
  logic             clr_err;
  logic             out_valid;
  logic             word_err;
  logic             frame_done;
  logic             frame_err;
  logic [CNT_W-1:0] frame_len;
  logic             err_sticky;
  logic [CNT_W-1:0] err_count;

  parity_stream_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .odd_mode(odd_mode), .in_valid(in_valid),
    .in_data(in_data), .in_par(in_par), .in_last(in_last), .clr_err(clr_err),
    .out_valid(out_valid), .word_err(word_err), .frame_done(frame_done),
    .frame_err(frame_err), .frame_len(frame_len), .err_sticky(err_sticky),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit word_err;
    bit frame_done;
    bit frame_err;
    int frame_len;
    bit sticky;
    int count;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;

  // Reference model state
  bit   m_in_frame;
  bit   m_mode;
  bit   m_errs[$];
  bit   m_ferr;
  int   m_flen;
  bit   m_sticky;
  int   m_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic bit word_bad(input logic [WIDTH-1:0] d, input logic p, input bit odd);
    int ones;
    ones = $countones({d, p});
    return odd ? (ones % 2 == 0) : (ones % 2 == 1);
  endfunction

  task automatic model_reset();
    m_in_frame = 1'b0;
    m_mode     = 1'b0;
    m_errs.delete();
    m_ferr     = 1'b0;
    m_flen     = 0;
    m_sticky   = 1'b0;
    m_count    = 0;
  endtask

  task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit p, input bit l,
                       input bit odd, input bit clr, input bit r);
    bit   e;
    exp_t x;
    in_valid = v; in_data = d; in_par = p; in_last = l;
    odd_mode = odd; clr_err = clr; rst = r;
    @(posedge clk);
    e = 1'b0;
    if (r) begin
      model_reset();
    end else begin
      if (v) begin
        if (!m_in_frame) begin
          m_mode = odd;
          m_errs.delete();
        end
        e = word_bad(d, p, m_mode);
        m_errs.push_back(e);
        m_in_frame = 1'b1;
      end
      if (e) m_sticky = 1'b1;
      else if (clr) m_sticky = 1'b0;
`ifdef PARITY_ERR_CNT_EN
      if (clr) m_count = e ? 1 : 0;
      else if (e && m_count < MAXV) m_count++;
`else
      m_count = 0;
`endif
      if (v) begin
        if (l) begin
          m_ferr = 1'b0;
          foreach (m_errs[i]) if (m_errs[i]) m_ferr = 1'b1;
          m_flen = (m_errs.size() > MAXV) ? MAXV : m_errs.size();
          m_in_frame = 1'b0;
        end
        x.word_err = e; x.frame_done = l; x.frame_err = m_ferr;
        x.frame_len = m_flen; x.sticky = m_sticky; x.count = m_count;
        sb_q.push_back(x);
      end
    end
    #1;
    if (r) begin
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_frame_done", 32'(frame_done), 0);
      chk("rst_frame_err", 32'(frame_err), 0);
      chk("rst_frame_len", 32'(frame_len), 0);
      chk("rst_sticky", 32'(err_sticky), 0);
      chk("rst_count", 32'(err_count), 0);
    end
  endtask

  // Monitor: pops one expectation per presented output word
  always @(negedge clk) begin
    exp_t x;
    if (mon_en) begin
      if (out_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out_valid: got 1 expected 0 at %0t", $time);
        end else begin
          x = sb_q.pop_front();
          chk("word_err", 32'(word_err), 32'(x.word_err));
          chk("frame_done", 32'(frame_done), 32'(x.frame_done));
          chk("frame_err", 32'(frame_err), 32'(x.frame_err));
          chk("frame_len", 32'(frame_len), 32'(x.frame_len));
          chk("err_sticky", 32'(err_sticky), 32'(x.sticky));
          chk("err_count", 32'(err_count), 32'(x.count));
          $display("[TB] word: err=%0b done=%0b ferr=%0b flen=%0d sticky=%0b cnt=%0d",
                   word_err, frame_done, frame_err, frame_len, err_sticky, err_count);
        end
      end else begin
        chk("idle_word_err", 32'(word_err), 0);
        chk("idle_frame_done", 32'(frame_done), 0);
      end
    end
  end

  initial begin
    model_reset();
    drive(0, '0, 0, 0, 0, 0, 1);
    drive(0, '0, 0, 0, 0, 0, 1);
    mon_en = 1'b1;

    // Even mode: 0x03/0 good, 0x07/0 bad
    drive(1, 8'h03, 0, 0, 0, 0, 0);
    drive(1, 8'h07, 0, 1, 0, 0, 0);
    // Odd mode three-word clean frame
    drive(1, 8'h01, 0, 0, 1, 0, 0);
    drive(1, 8'h00, 1, 0, 1, 0, 0);
    drive(1, 8'hFF, 1, 1, 1, 0, 0);
    drive(0, '0, 0, 0, 1, 0, 0);
    // Mode captured at frame start; mid-frame change ignored
    drive(1, 8'h00, 1, 0, 1, 0, 0);
    drive(0, '0, 0, 0, 0, 0, 0);
    drive(1, 8'h00, 1, 1, 0, 0, 0);
    // Single-word frame back-to-back with a 2-word frame carrying one bad word
    drive(1, 8'h01, 1, 1, 0, 0, 0);
    drive(1, 8'h00, 0, 0, 0, 0, 0);
    drive(1, 8'h01, 0, 1, 0, 0, 0);
    // Saturation of err_count and frame_len
    for (int i = 0; i < 9; i++) drive(1, 8'h01, 0, (i == 8), 0, 0, 0);
    drive(1, 8'h01, 0, 1, 0, 1, 0);
    drive(0, '0, 0, 0, 0, 1, 0);
    drive(0, '0, 0, 0, 0, 0, 0);
    chk("clr_sticky", 32'(err_sticky), 0);
    chk("clr_count", 32'(err_count), 0);
    // Reset mid-frame then a fresh single-word frame
    drive(1, 8'h01, 0, 0, 0, 0, 0);
    drive(1, 8'h00, 0, 0, 0, 0, 0);
    drive(0, '0, 0, 0, 0, 0, 1);
    drive(1, 8'h00, 0, 1, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      drive(($urandom_range(0, 3) != 0), WIDTH'($urandom), 1'($urandom),
            ($urandom_range(0, 4) == 0), 1'($urandom),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 99) == 0));
    end
    drive(0, '0, 0, 0, 0, 0, 0);
    drive(0, '0, 0, 0, 0, 0, 0);
    chk("scoreboard_drained", 32'(sb_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
